// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and the MEM stage (MEM has fixed priority).
// Optional bus watchdog: define ARB_TIMEOUT_EN to force completion after TIMEOUT cycles without bus_ack.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_adv,
    input  logic          if_re,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          mem_re,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_stall,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack,
    output logic          arb_err
);

    typedef enum logic [1:0] {IDLE, BUS_MEM, BUS_IF} state_e;

    state_e        state_q, state_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic          if_done_q, if_done_d;
    logic          mem_done_q, mem_done_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] mem_rdata_q, mem_rdata_d;
    logic          arb_err_q, arb_err_d;
    logic          mem_req;
    logic          tmo_hit;
    logic [DW-1:0] done_data;

    assign mem_req   = mem_re | mem_we;
    assign done_data = bus_ack ? bus_rdata : DW'(32'hDEADBEEF);

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter is held at zero in IDLE so it starts clean on every bus transaction.
    assign tmo_cnt_d = (state_q == IDLE) ? '0 : tmo_cnt_q + TW'(1);
    assign tmo_hit   = (state_q != IDLE) && !bus_ack && (tmo_cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        arb_err_d   = arb_err_q | tmo_hit;
        if_done_d   = pipe_adv ? 1'b0 : if_done_q;
        mem_done_d  = pipe_adv ? 1'b0 : mem_done_q;

        case (state_q)
            IDLE: begin
                if (mem_req && !mem_done_q) begin
                    state_d     = BUS_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                end else if (if_re && !if_done_q) begin
                    state_d     = BUS_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                end
            end
            // A requester that dropped its request before completion gets no result and no done.
            BUS_MEM: begin
                if (bus_ack || tmo_hit) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    if (mem_req) begin
                        mem_done_d = 1'b1;
                        if (!bus_we_q) mem_rdata_d = done_data;
                    end
                end
            end
            BUS_IF: begin
                if (bus_ack || tmo_hit) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    if (if_re) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = done_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            arb_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            arb_err_q   <= arb_err_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign arb_err   = arb_err_q;
    assign if_stall  = if_re & ~if_done_q;
    assign mem_stall = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle plus literal spot checks.
module tb_mem_port_arbiter;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0, rst = 1'b1, pipe_adv = 1'b0;
    logic        if_re = 1'b0, mem_re = 1'b0, mem_we = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        if_stall, mem_stall, bus_req, bus_we, arb_err;
    logic        bus_ack = 1'b0;

    int n_chk = 0, n_err = 0;
    bit chk_on = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .pipe_adv(pipe_adv),
        .if_re(if_re), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory-side responder: acks after ack_dly extra cycles of bus_req.
    int          ack_dly = 0, ack_cnt = 0;
    bit          ack_en = 1, rsp_mode = 1;
    logic [31:0] rsp_data = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_ack = 1'b0;
            ack_cnt = 0;
        end else begin
            #1;
            if (bus_ack) begin
                bus_ack = 1'b0;
                ack_cnt = 0;
            end else if (bus_req && ack_en) begin
                if (ack_cnt == ack_dly) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rsp_mode ? (bus_addr ^ 32'hA5A5_0000) : rsp_data;
                end else begin
                    ack_cnt++;
                end
            end
        end
    end

    // Model: who owns the bus, what it asked for, and each port's done flag and result.
    int          owner;          // 0 none, 1 MEM, 2 IF
    int          m_wait;
    bit          m_req, m_we, m_if_done, m_mem_done, m_err, old_if, old_mem, forced;
    logic [31:0] m_addr, m_wdata, m_if_rd, m_mem_rd, result;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owner = 0; m_wait = 0; m_req = 0; m_we = 0; m_err = 0;
            m_if_done = 0; m_mem_done = 0;
            m_addr = '0; m_wdata = '0; m_if_rd = '0; m_mem_rd = '0;
        end else begin
            old_if  = m_if_done;
            old_mem = m_mem_done;
            if (pipe_adv) begin
                m_if_done  = 0;
                m_mem_done = 0;
            end
            if (owner == 0) begin
                if ((mem_re || mem_we) && !old_mem) begin
                    owner = 1; m_req = 1; m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata; m_wait = 0;
                end else if (if_re && !old_if) begin
                    owner = 2; m_req = 1; m_we = 0; m_addr = if_addr; m_wait = 0;
                end
            end else begin
                forced = 0;
`ifdef ARB_TIMEOUT_EN
                if (!bus_ack) begin
                    m_wait++;
                    if (m_wait >= TMO) forced = 1;
                end
`endif
                if (bus_ack || forced) begin
                    result = bus_ack ? bus_rdata : 32'hDEADBEEF;
                    if (owner == 1 && (mem_re || mem_we)) begin
                        m_mem_done = 1;
                        if (!m_we) m_mem_rd = result;
                    end
                    if (owner == 2 && if_re) begin
                        m_if_done = 1;
                        m_if_rd   = result;
                    end
                    if (forced) m_err = 1;
                    owner = 0;
                    m_req = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_on) begin
            check("bus_req", 32'(bus_req), 32'(m_req));
            check("if_stall", 32'(if_stall), 32'(if_re & ~m_if_done));
            check("mem_stall", 32'(mem_stall), 32'((mem_re | mem_we) & ~m_mem_done));
            check("if_rdata", if_rdata, m_if_rd);
            check("mem_rdata", mem_rdata, m_mem_rd);
            check("arb_err", 32'(arb_err), 32'(m_err));
            if (m_req) begin
                check("bus_we", 32'(bus_we), 32'(m_we));
                check("bus_addr", bus_addr, m_addr);
                if (m_we) check("bus_wdata", bus_wdata, m_wdata);
            end
        end
    end

    // Waits (bounded) until the selected output reaches val; n = cycles taken.
    task automatic wait_for(input int what, input bit val, input string name, output int n);
        bit cur;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            case (what)
                0:       cur = bus_req;
                1:       cur = if_stall;
                default: cur = mem_stall;
            endcase
        end while (cur != val && n < 50);
        if (cur != val) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_%s: got timeout expected %0d", name, val);
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic advance();
        pipe_adv = 1'b1; if_re = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
        cyc();
        pipe_adv = 1'b0;
        cyc();
    endtask

    int n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_arb_err", 32'(arb_err), 32'd0);
        rst = 1'b0;
        chk_on = 1;
        cyc();

        // IF-only read, ack two cycles after bus_req
        ack_dly = 2; rsp_mode = 0; rsp_data = 32'h1234;
        if_re = 1'b1; if_addr = 32'h40;
        wait_for(1, 1'b0, "if_done", n);
        check("if_latency", 32'(n), 32'd4);
        check("if_rdata_1234", if_rdata, 32'h1234);
        pipe_adv = 1'b1;
        cyc();
        pipe_adv = 1'b0;
        check("if_stall_after_adv", 32'(if_stall), 32'd1);
        if_re = 1'b0;
        cyc();

        // Conflict: MEM first, then IF
        ack_dly = 0; rsp_mode = 1;
        if_re = 1'b1; if_addr = 32'h100; mem_re = 1'b1; mem_addr = 32'h200;
        wait_for(0, 1'b1, "req1", n);
        check("conf_first_addr", bus_addr, 32'h200);
        check("conf_if_stall1", 32'(if_stall), 32'd1);
        wait_for(2, 1'b0, "mem_done", n);
        check("conf_mem_rdata", mem_rdata, 32'hA5A5_0200);
        check("conf_if_stall2", 32'(if_stall), 32'd1);
        wait_for(0, 1'b1, "req2", n);
        check("conf_second_addr", bus_addr, 32'h100);
        wait_for(1, 1'b0, "if_done2", n);
        check("conf_if_rdata", if_rdata, 32'hA5A5_0100);
        advance();

        // Write held stable until ack; mem_rdata untouched
        ack_dly = 2;
        mem_we = 1'b1; mem_addr = 32'h80; mem_wdata = 32'hCAFE;
        wait_for(0, 1'b1, "wr_req", n);
        check("wr_bus_we", 32'(bus_we), 32'd1);
        check("wr_bus_addr", bus_addr, 32'h80);
        check("wr_bus_wdata", bus_wdata, 32'hCAFE);
        cyc();
        check("wr_hold_wdata", bus_wdata, 32'hCAFE);
        wait_for(2, 1'b0, "wr_done", n);
        check("wr_mem_rdata", mem_rdata, 32'hA5A5_0200);
        advance();

        // Flush: IF drops request mid-transaction
        rsp_mode = 0; rsp_data = 32'h55;
        if_re = 1'b1; if_addr = 32'h300;
        wait_for(0, 1'b1, "fl_req", n);
        check("fl_bus_addr", bus_addr, 32'h300);
        if_re = 1'b0;
        wait_for(0, 1'b0, "fl_end", n);
        check("fl_if_rdata", if_rdata, 32'hA5A5_0100);
        cyc();
        check("fl_idle", 32'(bus_req), 32'd0);
        if_re = 1'b1;
        #1;
        check("fl_not_done", 32'(if_stall), 32'd1);
        if_re = 1'b0;
        cyc();

        // pipe_adv coinciding with ack: done set wins
        ack_dly = 0; rsp_mode = 1;
        mem_re = 1'b1; mem_addr = 32'h400;
        wait_for(0, 1'b1, "co_req", n);
        pipe_adv = 1'b1;
        cyc();
        pipe_adv = 1'b0;
        check("co_mem_stall", 32'(mem_stall), 32'd0);
        check("co_mem_rdata", mem_rdata, 32'hA5A5_0400);
        advance();

`ifdef ARB_TIMEOUT_EN
        // No ack: watchdog forces completion
        ack_en = 0;
        mem_re = 1'b1; mem_addr = 32'h500;
        wait_for(2, 1'b0, "tmo_done", n);
        check("tmo_latency", 32'(n), 32'd5);
        check("tmo_rdata", mem_rdata, 32'hDEADBEEF);
        check("tmo_err", 32'(arb_err), 32'd1);
        ack_en = 1;
        advance();
        check("tmo_err_sticky", 32'(arb_err), 32'd1);
`endif

        // Reset in the middle of a transaction
        ack_dly = 5;
        if_re = 1'b1; if_addr = 32'h600;
        wait_for(0, 1'b1, "rm_req", n);
        check("rm_req_high", 32'(bus_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rm_bus_req", 32'(bus_req), 32'd0);
        check("rm_bus_we", 32'(bus_we), 32'd0);
        check("rm_bus_addr", bus_addr, 32'd0);
        check("rm_if_rdata", if_rdata, 32'd0);
        check("rm_mem_rdata", mem_rdata, 32'd0);
        check("rm_arb_err", 32'(arb_err), 32'd0);
        if_re = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
